qdrc_cmd_sched: RTL

Command scheduler that sits directly upstream of the QDR controller top level in the same `clk0` domain. It buffers independent user write and read requests behind valid/ready handshakes and arbitrates them onto the controller's single shared-address strobe interface. It tracks outstanding reads with a tag FIFO and returns tagged read data when the controller signals `usr_rd_dvld`.

---
 rtl/qdrc_sched_pkg.sv | 30 +++
 rtl/qdrc_sync_fifo.sv | 61 ++++++
 rtl/qdrc_cmd_sched.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/qdrc_sched_pkg.sv
// Shared constants and record-width helpers for the QDR command scheduler.
package qdrc_sched_pkg;

  localparam logic GNT_WR = 1'b0;
  localparam logic GNT_RD = 1'b1;

  localparam int unsigned QDR_LATENCY = 10;

  localparam int unsigned DEF_DATA_WIDTH = 36;
  localparam int unsigned DEF_ADDR_WIDTH = 21;
  localparam int unsigned DEF_TAG_WIDTH  = 4;

  // Record widths: write request {addr,data}, read request {addr,tag}, response {tag,data}
  function automatic int unsigned wr_req_w(input int unsigned aw, input int unsigned dw);
    return aw + 2 * dw;
  endfunction

  function automatic int unsigned rd_req_w(input int unsigned aw, input int unsigned tw);
    return aw + tw;
  endfunction

  function automatic int unsigned rsp_w(input int unsigned tw, input int unsigned dw);
    return tw + 2 * dw;
  endfunction

  localparam int unsigned WR_REQ_W = wr_req_w(DEF_ADDR_WIDTH, DEF_DATA_WIDTH);
  localparam int unsigned RD_REQ_W = rd_req_w(DEF_ADDR_WIDTH, DEF_TAG_WIDTH);
  localparam int unsigned RSP_W    = rsp_w(DEF_TAG_WIDTH, DEF_DATA_WIDTH);

endpackage

// File: rtl/qdrc_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head and registered storage.
module qdrc_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  // Extra pointer MSB distinguishes full from empty when indices match
  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head_c  = mem_q[rd_ptr_q[PTR_W-1:0]];

  assign push_ok = push && !full_c;
  assign pop_ok  = pop && !empty_c;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/qdrc_cmd_sched.sv
// Buffers user write/read requests, arbitrates them onto the shared-address
// QDR strobe interface and returns tagged read data.
module qdrc_cmd_sched
  import qdrc_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 36,
  parameter int unsigned ADDR_WIDTH      = 21,
  parameter int unsigned TAG_WIDTH       = 4,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic                    clk0,
  input  logic                    reset_n,
  input  logic                    phy_rdy,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [2*DATA_WIDTH-1:0] wr_data,
  input  logic                    rd_valid,
  output logic                    rd_ready,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic [TAG_WIDTH-1:0]    rd_tag,
  output logic                    rsp_valid,
  output logic [TAG_WIDTH-1:0]    rsp_tag,
  output logic [2*DATA_WIDTH-1:0] rsp_data,
  output logic                    rsp_err,
  output logic                    usr_wr_strb,
  output logic                    usr_rd_strb,
  output logic [ADDR_WIDTH-1:0]   usr_addr,
  output logic [2*DATA_WIDTH-1:0] usr_wr_data,
  input  logic [2*DATA_WIDTH-1:0] usr_rd_data,
  input  logic                    usr_rd_dvld
);

  localparam int unsigned UW    = 2 * DATA_WIDTH;
  localparam int unsigned WR_W  = wr_req_w(ADDR_WIDTH, DATA_WIDTH);
  localparam int unsigned RD_W  = rd_req_w(ADDR_WIDTH, TAG_WIDTH);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [WR_W-1:0]      wr_head;
  logic [RD_W-1:0]      rd_head;
  logic [TAG_WIDTH-1:0] tag_head;
  logic                 wr_full, wr_empty;
  logic                 rd_full, rd_empty;
  logic                 tag_full, tag_empty;
  logic                 wr_elig, rd_elig;
  logic                 gnt_wr, gnt_rd;
  logic                 ret_ok;

  logic                  last_grant_q, last_grant_d;
  logic [CNT_W-1:0]      outstanding_q, outstanding_d;
  logic                  usr_wr_strb_q, usr_wr_strb_d;
  logic                  usr_rd_strb_q, usr_rd_strb_d;
  logic [ADDR_WIDTH-1:0] usr_addr_q, usr_addr_d;
  logic [UW-1:0]         usr_wr_data_q, usr_wr_data_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [TAG_WIDTH-1:0]  rsp_tag_q, rsp_tag_d;
  logic [UW-1:0]         rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;

  assign wr_ready = !wr_full;
  assign rd_ready = !rd_full;

  qdrc_sync_fifo #(.WIDTH(WR_W), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk       (clk0),
    .rst_n     (reset_n),
    .push      (wr_valid && wr_ready),
    .push_data ({wr_addr, wr_data}),
    .pop       (gnt_wr),
    .head_c    (wr_head),
    .full_c    (wr_full),
    .empty_c   (wr_empty)
  );

  qdrc_sync_fifo #(.WIDTH(RD_W), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
    .clk       (clk0),
    .rst_n     (reset_n),
    .push      (rd_valid && rd_ready),
    .push_data ({rd_addr, rd_tag}),
    .pop       (gnt_rd),
    .head_c    (rd_head),
    .full_c    (rd_full),
    .empty_c   (rd_empty)
  );

  qdrc_sync_fifo #(.WIDTH(TAG_WIDTH), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk       (clk0),
    .rst_n     (reset_n),
    .push      (gnt_rd),
    .push_data (rd_head[TAG_WIDTH-1:0]),
    .pop       (usr_rd_dvld),
    .head_c    (tag_head),
    .full_c    (tag_full),
    .empty_c   (tag_empty)
  );

  // Eligibility uses the outstanding count registered at the start of the cycle
  assign wr_elig = !wr_empty && phy_rdy;
  assign rd_elig = !rd_empty && phy_rdy && !tag_full &&
                   (outstanding_q < CNT_W'(MAX_OUTSTANDING));
  assign ret_ok  = usr_rd_dvld && !tag_empty;

  always_comb begin
    gnt_wr = 1'b0;
    gnt_rd = 1'b0;
    if (wr_elig && rd_elig) begin
      if (last_grant_q == GNT_RD) gnt_wr = 1'b1;
      else                        gnt_rd = 1'b1;
    end else if (wr_elig) begin
      gnt_wr = 1'b1;
    end else if (rd_elig) begin
      gnt_rd = 1'b1;
    end
  end

  always_comb begin
    last_grant_d  = last_grant_q;
    outstanding_d = outstanding_q;
    usr_wr_strb_d = gnt_wr;
    usr_rd_strb_d = gnt_rd;
    usr_addr_d    = usr_addr_q;
    usr_wr_data_d = usr_wr_data_q;
    rsp_valid_d   = ret_ok;
    rsp_tag_d     = rsp_tag_q;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q || (usr_rd_dvld && tag_empty);

    if (gnt_wr) begin
      usr_addr_d    = wr_head[WR_W-1:UW];
      usr_wr_data_d = wr_head[UW-1:0];
      last_grant_d  = GNT_WR;
    end else if (gnt_rd) begin
      usr_addr_d    = rd_head[RD_W-1:TAG_WIDTH];
      last_grant_d  = GNT_RD;
    end

    // Simultaneous issue and return leave the count unchanged
    case ({gnt_rd, ret_ok})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (ret_ok) begin
      rsp_tag_d  = tag_head;
      rsp_data_d = usr_rd_data;
    end
  end

  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q  <= GNT_RD;
      outstanding_q <= '0;
      usr_wr_strb_q <= 1'b0;
      usr_rd_strb_q <= 1'b0;
      usr_addr_q    <= '0;
      usr_wr_data_q <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_tag_q     <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      last_grant_q  <= last_grant_d;
      outstanding_q <= outstanding_d;
      usr_wr_strb_q <= usr_wr_strb_d;
      usr_rd_strb_q <= usr_rd_strb_d;
      usr_addr_q    <= usr_addr_d;
      usr_wr_data_q <= usr_wr_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_tag_q     <= rsp_tag_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign usr_wr_strb = usr_wr_strb_q;
  assign usr_rd_strb = usr_rd_strb_q;
  assign usr_addr    = usr_addr_q;
  assign usr_wr_data = usr_wr_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_tag     = rsp_tag_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;

endmodule
